// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: data widths,
// the buffered MDU result layout and the starvation FSM states.
package regfile_wb_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ENTRY_W    = REG_ADDR_W + XLEN;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } fifo_entry_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_HOLD   = 1'b1
  } arb_state_e;
endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Circular buffer of MDU results; the head entry is visible combinationally
// so the arbiter can write it in the same cycle it is popped.
module wb_result_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [ENTRY_W-1:0]       din_i,
  input  logic                     pop_i,
  output logic [ENTRY_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Fullness is judged on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port: pipeline writeback has priority, MDU
// results queue in a FIFO, with a scoreboard stall and starvation hold.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_wr_en_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_data_i,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  output logic        sb_stall_o,
  output logic        hold_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_data_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [ENTRY_W-1:0] head_vec;
  fifo_entry_t        head, push_entry;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic               unused_full;

  arb_state_e         state_q, state_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic [31:0]        pending_q, pending_d;
  logic               grant_pipe, grant_fifo;

  assign unused_full = fifo_full;
  assign head        = fifo_entry_t'(head_vec);
  assign push_entry  = '{rd: mdu_rd_i, data: mdu_data_i};
  assign mdu_ready_o = (fifo_count < CW'(FIFO_DEPTH));
  // x0 results are handshaked but dropped before they reach the queue.
  assign fifo_push   = mdu_valid_i && mdu_ready_o && (mdu_rd_i != '0);
  assign fifo_pop    = grant_fifo && !rst_i;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (head_vec),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (pipe_wr_en_i) begin
          grant_pipe = 1'b1;
          if (!fifo_empty) begin
            starve_d = starve_q + SW'(1);
            if (starve_d == SW'(STARVE_LIMIT)) state_d = ST_HOLD;
          end else begin
            starve_d = '0;
          end
        end else begin
          grant_fifo = !fifo_empty;
          starve_d   = '0;
        end
      end
      ST_HOLD: begin
        // Pipeline request ignored; the frozen MEM/WB stage re-presents it.
        grant_fifo = !fifo_empty;
        starve_d   = '0;
        state_d    = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    rf_rd_o   = grant_fifo ? head.rd   : pipe_rd_i;
    rf_data_o = grant_fifo ? head.data : pipe_data_i;
    rf_we_o   = !rst_i && (grant_fifo || (grant_pipe && (pipe_rd_i != '0)));
  end

  // Set after clear so a same-cycle reissue of a retiring rd stays pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) pending_d[head.rd] = 1'b0;
    if (issue_i)  pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign sb_stall_o = pending_q[id_rs1_i] | pending_q[id_rs2_i] | pending_q[id_rd_i];
  assign hold_o     = (state_q == ST_HOLD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_NORMAL;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end
endmodule
